fifo_ring_width_2_sdffe: RTL and testbench

Ring-buffer FIFO with valid/ready handshakes on both sides and synchronous, active-high reset. It sits directly upstream of the fixed-latency sequential delay stage in the basic flip-flop fixture set. It absorbs bursty 2-bit producer traffic and presents words in order, show-ahead, to the delay stage's `d` input. All state lives in enable-gated, synchronously reset flip-flops (sdffe style), so the block doubles as a pattern-matching fixture for reset/enable flop inference.

---
 rtl/fifo_ring_width_2_sdffe_if.sv | 26 ++
 rtl/fifo_ring_width_2_sdffe.sv | 77 +++++++
 tb/tb_fifo_ring_width_2_sdffe.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ring_width_2_sdffe_if.sv
// Handshake bundle for the ring FIFO: producer side (in_*), consumer side (out_*), status.
interface fifo_ring_width_2_sdffe_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             overflow;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, overflow
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/fifo_ring_width_2_sdffe.sv
// Show-ahead ring FIFO with sticky overflow; 1-cycle write-to-read, 1 word/cycle sustained.
// in_ready/out_valid come from the count register only; a push while full is dropped and flagged.
module fifo_ring_width_2_sdffe #(
  parameter int FIFO_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  fifo_ring_width_2_sdffe_if.slave     bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  always_comb begin
    full  = (count == FULL_CNT);
    empty = (count == '0);
    push  = bus.in_valid && !full;
    pop   = !empty && bus.out_ready;
  end

  // Storage is deliberately not reset; only the write enable gates it.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Concurrent push and pop leave occupancy untouched, so only one-sided traffic enables the flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (push ^ pop) begin
      count <= push ? count + CW'(1) : count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (bus.in_valid && full) begin
      overflow <= 1'b1;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_fifo_ring_width_2_sdffe.sv
// Randomized and directed bench for the ring FIFO against a queue-based reference model.
module tb_fifo_ring_width_2_sdffe;
  localparam int W = 2;
  localparam int D = 4;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  fifo_ring_width_2_sdffe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_ring_width_2_sdffe #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: contents as a queue, plus a sticky overflow bit.
  logic [W-1:0] model_q[$];
  logic         model_ovf;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  // Advance one clock: decide push/pop from the model, record DUT word on each pop.
  task automatic tick();
    bit do_push;
    bit do_pop;
    do_pop  = bus.out_ready && (model_q.size() > 0);
    do_push = bus.in_valid && (model_q.size() < D);
    if (!reset && do_pop) begin
      got_q.push_back(bus.out_data);
      exp_q.push_back(model_q[0]);
    end
    @(posedge clk);
    if (reset) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (bus.in_valid && model_q.size() == D) model_ovf = 1'b1;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(bus.in_data);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.count !== 0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
  endtask

  task automatic test_fill();
    logic [W-1:0] words [4];
    words = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      tick();
    end
    idle_inputs();
    checks++;
    if (bus.count !== 4) begin errors++; $display("FAIL fill_count got=%0d want=4", bus.count); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b want=0", bus.in_ready); end
    checks++;
    if (bus.out_data !== 2'b01) begin errors++; $display("FAIL fill_out_data got=%b want=01", bus.out_data); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] want [4];
    want = '{2'b01, 2'b10, 2'b11, 2'b00};
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b11;
    tick();
    idle_inputs();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", bus.overflow); end
    checks++;
    if (bus.count !== 4) begin errors++; $display("FAIL ovf_count got=%0d want=4", bus.count); end
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
    got_q.delete();
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    idle_inputs();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL ovf_drain_len got=%0d want=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== want[i]) begin
          errors++;
          $display("FAIL ovf_drain_word[%0d] got=%b want=%b", i, got_q[i], want[i]);
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain got=%b want=1", bus.overflow); end
  endtask

  task automatic test_wrap();
    int sent;
    int cyc;
    do_reset();
    sent = 0;
    cyc  = 0;
    while (got_q.size() < 12 && cyc < 200) begin
      bus.in_valid  = (sent < 12);
      bus.in_data   = W'(sent % 4);
      bus.out_ready = cyc[0];
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      cyc++;
      checks++;
      if (bus.count > 4 || bus.count !== model_q.size()) begin
        errors++;
        $display("FAIL wrap_count cyc=%0d got=%0d want=%0d", cyc, bus.count, model_q.size());
      end
    end
    idle_inputs();
    checks++;
    if (got_q.size() != 12) begin
      errors++;
      $display("FAIL wrap_len got=%0d want=12 (cycle budget)", got_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_q[i] !== W'(i % 4)) begin
          errors++;
          $display("FAIL wrap_word[%0d] got=%b want=%0d", i, got_q[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] first;
    do_reset();
    first = W'($urandom_range(0, 3));
    bus.in_valid = 1'b1;
    bus.in_data  = first;
    tick();
    bus.in_data  = W'($urandom_range(0, 3));
    tick();
    bus.in_data   = 2'b10;
    bus.out_ready = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.count !== 2) begin errors++; $display("FAIL simul_count got=%0d want=2", bus.count); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== first) begin
      errors++;
      $display("FAIL simul_popped got=%b want=%b n=%0d", got_q.size() ? got_q[0] : 2'bxx, first, got_q.size());
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b01;
    tick();
    bus.in_data  = 2'b11;
    tick();
    checks++;
    if (bus.count !== 4) begin errors++; $display("FAIL simul_full got=%0d want=4", bus.count); end
    bus.in_data   = 2'b00;
    bus.out_ready = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.count !== 3) begin errors++; $display("FAIL full_pop_count got=%0d want=3", bus.count); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b want=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    checks++;
    if (got_q != exp_q || got_q.size() != 5) begin
      errors++;
      $display("FAIL simul_drain got_n=%0d want_n=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(i + 1);
      tick();
    end
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 2'b11;
    bus.out_ready = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (bus.count !== 0) begin errors++; $display("FAIL midrst_count got=%0d want=0", bus.count); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got=%b want=0", bus.overflow); end
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_no_pulse out_valid=%b pops=%0d want 0/0", bus.out_valid, got_q.size());
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_data   = W'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 50);
      #1;
      checks++;
      if (bus.count !== model_q.size() || bus.in_ready !== (model_q.size() < D) ||
          bus.out_valid !== (model_q.size() > 0) || bus.overflow !== model_ovf) begin
        errors++;
        $display("FAIL rand_state cyc=%0d count=%0d/%0d rdy=%b vld=%b ovf=%b/%b", c,
                 bus.count, model_q.size(), bus.in_ready, bus.out_valid, bus.overflow, model_ovf);
      end
      if (model_q.size() > 0) begin
        checks++;
        if (bus.out_data !== model_q[0]) begin
          errors++;
          $display("FAIL rand_data cyc=%0d got=%b want=%b", c, bus.out_data, model_q[0]);
        end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL rand_order got_n=%0d want_n=%0d", got_q.size(), exp_q.size());
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    model_ovf = 1'b0;
    reset     = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
